// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller.
// Debounces the mode/inc/dec keys, walks hour -> minute -> second edit fields,
// then strobes set_en to load the edited time into the clock counter.
// Optional feature: define SET_TIMEOUT_EN to abort an idle edit session
// after TIMEOUT_CYC cycles without any key press.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int BLINK_CYC    = 12_500_000
`ifdef SET_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 500_000_000
`endif
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [5:0] hour_now,
  input  logic [5:0] minute_now,
  input  logic [5:0] second_now,
  output logic       set_en,
  output logic [5:0] hour_set,
  output logic [5:0] minute_set,
  output logic [5:0] second_set,
  output logic       edit_active,
  output logic [2:0] blink_mask
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int HL_W = $clog2(HOLD_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);

  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        key_raw, key_meta, key_sync, key_deb, key_press;
  logic [DB_W-1:0]   db_cnt [3];
  logic [HL_W-1:0]   hold_cnt;
  logic [BL_W-1:0]   blink_cnt;
  logic              blink_ph;
  logic              mode_ev, inc_ev, dec_ev, blink_restart, timeout_hit;

  function automatic logic is_edit(input state_t s);
    return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
  endfunction

  // One step up or down with wrap; >= keeps an out-of-range snapshot legal.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                           input logic up);
    if (up) return (v >= max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max : ((v > max) ? max : v - 6'd1);
  endfunction

  // bit0 = mode, bit1 = inc, bit2 = dec (all active-low on the pins)
  assign key_raw = {key_dec_n, key_inc_n, key_mode_n};

  // Two-flop synchroniser; released (1) out of reset.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYC stable cycles; pulse on press.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      key_deb   <= '1;
      key_press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        key_press[i] <= 1'b0;
        if (key_sync[i] == key_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_cnt[i]    <= '0;
          key_deb[i]   <= key_sync[i];
          key_press[i] <= ~key_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Mode wins over inc/dec; inc and dec together cancel. Keys are dead in COMMIT.
  assign mode_ev = key_press[0] && (state_q != COMMIT);
  assign inc_ev  = key_press[1] && !key_press[2] && !key_press[0] && is_edit(state_q);
  assign dec_ev  = key_press[2] && !key_press[1] && !key_press[0] && is_edit(state_q);

`ifdef SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = is_edit(state_q) && (key_press == 3'b000) &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Inactivity counter: runs only while editing, any press restarts it.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en)                              to_cnt <= '0;
    else if (!is_edit(state_q) || |key_press)  to_cnt <= '0;
    else                                        to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mode_ev) state_d = EDIT_H;
      EDIT_H:  if (mode_ev) state_d = EDIT_M;
      EDIT_M:  if (mode_ev) state_d = EDIT_S;
      EDIT_S:  if (mode_ev) state_d = COMMIT;
      COMMIT:  if (hold_cnt == HL_W'(HOLD_CYC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // Commit hold timer: counts the cycles spent in COMMIT.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en)              hold_cnt <= '0;
    else if (state_q == COMMIT) hold_cnt <= hold_cnt + 1'b1;
    else                        hold_cnt <= '0;
  end

  // Edit fields: snapshot on entry, step on inc/dec, hold otherwise.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      hour_set   <= '0;
      minute_set <= '0;
      second_set <= '0;
    end else if (state_q == IDLE && mode_ev) begin
      hour_set   <= hour_now;
      minute_set <= minute_now;
      second_set <= second_now;
    end else if (inc_ev || dec_ev) begin
      case (state_q)
        EDIT_H:  hour_set   <= step_wrap(hour_set,   6'd23, inc_ev);
        EDIT_M:  minute_set <= step_wrap(minute_set, 6'd59, inc_ev);
        EDIT_S:  second_set <= step_wrap(second_set, 6'd59, inc_ev);
        default: ;
      endcase
    end
  end

  // Registered edit indicator, aligned with the EDIT states.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) edit_active <= 1'b0;
    else           edit_active <= is_edit(state_d);
  end

  assign blink_restart = (state_d != state_q) || inc_ev || dec_ev;

  // Blink phase: free-running toggle, restarted visible on any field change or edit.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_restart) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Only the field being edited blinks.
  always_comb begin
    blink_mask = 3'b000;
    case (state_q)
      EDIT_H:  blink_mask = {blink_ph, 2'b00};
      EDIT_M:  blink_mask = {1'b0, blink_ph, 1'b0};
      EDIT_S:  blink_mask = {2'b00, blink_ph};
      default: blink_mask = 3'b000;
    endcase
  end

  assign set_en = (state_q == COMMIT);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int BLNK = 3;
  localparam int TOUT = 40;

  logic       clk = 1'b0;
  logic       reset_en;
  logic       key_mode_n, key_inc_n, key_dec_n;
  logic [5:0] hour_now, minute_now, second_now;
  logic       set_en, edit_active;
  logic [5:0] hour_set, minute_set, second_set;
  logic [2:0] blink_mask;

  int total  = 0;
  int passed = 0;

  time_set_ctrl #(
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC    (HOLD),
    .BLINK_CYC   (BLNK)
`ifdef SET_TIMEOUT_EN
    ,.TIMEOUT_CYC(TOUT)
`endif
  ) dut (
    .CLK_50     (clk),
    .reset_en   (reset_en),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .key_dec_n  (key_dec_n),
    .hour_now   (hour_now),
    .minute_now (minute_now),
    .second_now (second_now),
    .set_en     (set_en),
    .hour_set   (hour_set),
    .minute_set (minute_set),
    .second_set (second_set),
    .edit_active(edit_active),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
    $fatal(1);
  end

  typedef struct {
    logic [2:0] keys;   // {dec, inc, mode}
    int         reps;
    logic [5:0] h, m, s;
    logic [2:0] field;  // blink bit allowed for the current field
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic press(input logic [2:0] k);
    @(negedge clk);
    key_mode_n = ~k[0];
    key_inc_n  = ~k[1];
    key_dec_n  = ~k[2];
    repeat (DB + 6) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    repeat (DB + 6) @(negedge clk);
  endtask

  initial begin
    logic saw0, saw1, other, found, stable;
    int   cnt, n;

    reset_en = 1'b0;
    key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
    hour_now = 6'd0; minute_now = 6'd0; second_now = 6'd0;

    vecs[0]  = '{3'b001,  1, 6'd13, 6'd45, 6'd7,  3'b100};
    vecs[1]  = '{3'b010, 11, 6'd0,  6'd45, 6'd7,  3'b100};
    vecs[2]  = '{3'b100,  1, 6'd23, 6'd45, 6'd7,  3'b100};
    vecs[3]  = '{3'b010,  1, 6'd0,  6'd45, 6'd7,  3'b100};
    vecs[4]  = '{3'b011,  1, 6'd0,  6'd45, 6'd7,  3'b010};
    vecs[5]  = '{3'b010, 15, 6'd0,  6'd0,  6'd7,  3'b010};
    vecs[6]  = '{3'b100,  1, 6'd0,  6'd59, 6'd7,  3'b010};
    vecs[7]  = '{3'b110,  1, 6'd0,  6'd59, 6'd7,  3'b010};
    vecs[8]  = '{3'b001,  1, 6'd0,  6'd59, 6'd7,  3'b001};
    vecs[9]  = '{3'b100,  8, 6'd0,  6'd59, 6'd59, 3'b001};
    vecs[10] = '{3'b010,  1, 6'd0,  6'd59, 6'd0,  3'b001};
    vecs[11] = '{3'b010,  1, 6'd0,  6'd59, 6'd1,  3'b001};
    vecs[12] = '{3'b110,  1, 6'd0,  6'd59, 6'd1,  3'b001};

    // Reset held while keys chatter.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_mode_n = i[0]; key_inc_n = ~i[0]; key_dec_n = i[1];
    end
    check("rst_set_en",      32'(set_en),      32'd0);
    check("rst_hour_set",    32'(hour_set),    32'd0);
    check("rst_minute_set",  32'(minute_set),  32'd0);
    check("rst_second_set",  32'(second_set),  32'd0);
    check("rst_edit_active", 32'(edit_active), 32'd0);
    check("rst_blink_mask",  32'(blink_mask),  32'd0);
    key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
    #2 reset_en = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_edit", 32'(edit_active), 32'd0);
    check("post_rst_set_en", 32'(set_en), 32'd0);

    // Two-cycle glitch on mode must be rejected.
    key_mode_n = 1'b0;
    repeat (2) @(negedge clk);
    key_mode_n = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_edit", 32'(edit_active), 32'd0);
    check("glitch_hour", 32'(hour_set), 32'd0);

    hour_now = 6'd13; minute_now = 6'd45; second_now = 6'd7;

    // Table of key actions and resulting field values.
    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].keys);
      check($sformatf("v%0d_hour", i),   32'(hour_set),   32'(vecs[i].h));
      check($sformatf("v%0d_minute", i), 32'(minute_set), 32'(vecs[i].m));
      check($sformatf("v%0d_second", i), 32'(second_set), 32'(vecs[i].s));
      check($sformatf("v%0d_edit", i),   32'(edit_active), 32'd1);
      check($sformatf("v%0d_set_en", i), 32'(set_en), 32'd0);
      check($sformatf("v%0d_blink_other", i), 32'(blink_mask & ~vecs[i].field), 32'd0);
      if (i == 0) begin
        saw0 = 1'b0; saw1 = 1'b0; other = 1'b0;
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (blink_mask[2]) saw1 = 1'b1; else saw0 = 1'b1;
          if (blink_mask[1:0] != 2'b00) other = 1'b1;
        end
        check("blink_h_toggles", 32'(saw0 & saw1), 32'd1);
        check("blink_h_only",    32'(other), 32'd0);
      end
    end

    // inc in EDIT_S: blink phase restarts visible on the edit.
    @(negedge clk);
    key_inc_n = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (second_set != 6'd1) found = 1'b1;
    end
    check("inc_seen", 32'(found), 32'd1);
    check("restart_blink0", 32'(blink_mask), 32'd0);
    @(negedge clk);
    check("restart_blink1", 32'(blink_mask), 32'd0);
    key_inc_n = 1'b1;
    repeat (12) @(negedge clk);
    check("sec_after_inc", 32'(second_set), 32'd2);

    // Commit: set_en high exactly HOLD cycles with stable values; keys ignored.
    @(negedge clk);
    key_mode_n = 1'b0;
    cnt = 0; stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (set_en) begin
        if (cnt == 0) begin key_mode_n = 1'b1; key_inc_n = 1'b0; end
        cnt++;
        if (hour_set != 6'd0 || minute_set != 6'd59 || second_set != 6'd2) stable = 1'b0;
      end
    end
    check("commit_len",    32'(cnt), 32'(HOLD));
    check("commit_stable", 32'(stable), 32'd1);
    check("commit_idle_set_en", 32'(set_en), 32'd0);
    check("commit_idle_edit", 32'(edit_active), 32'd0);
    key_inc_n = 1'b1;
    key_mode_n = 1'b1;
    repeat (15) @(negedge clk);
    check("hold_hour",   32'(hour_set),   32'd0);
    check("hold_minute", 32'(minute_set), 32'd59);
    check("hold_second", 32'(second_set), 32'd2);
    check("idle_blink",  32'(blink_mask), 32'd0);
    check("idle_edit",   32'(edit_active), 32'd0);

    // Reset asserted mid-commit.
    press(3'b001);
    check("re_enter_hour", 32'(hour_set), 32'd13);
    press(3'b001);
    press(3'b001);
    @(negedge clk);
    key_mode_n = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (set_en) found = 1'b1;
    end
    check("mid_commit_reached", 32'(found), 32'd1);
    key_mode_n = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_en = 1'b0;
    #1;
    check("abort_set_en", 32'(set_en), 32'd0);
    check("abort_hour",   32'(hour_set), 32'd0);
    #4 reset_en = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle_edit",   32'(edit_active), 32'd0);
    check("abort_idle_set_en", 32'(set_en), 32'd0);

`ifdef SET_TIMEOUT_EN
    // Idle edit session times out with no load.
    press(3'b001);
    press(3'b001);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (set_en) stable = 1'b0;
    end
    check("to_still_edit", 32'(edit_active), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (set_en) stable = 1'b0;
      if (!edit_active) found = 1'b1;
    end
    check("to_idle", 32'(found), 32'd1);
    check("to_no_set_en", 32'(stable), 32'd1);

    // Inc press around cycle 30 defers the timeout by a full period.
    press(3'b001);
    press(3'b001);
    repeat (10) @(negedge clk);
    key_inc_n = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (minute_set != 6'd45) found = 1'b1;
    end
    check("to_inc_seen", 32'(found), 32'd1);
    key_inc_n = 1'b1;
    n = 0; found = 1'b0; stable = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      n++;
      if (set_en) stable = 1'b0;
      if (!edit_active) found = 1'b1;
    end
    check("to_defer_fell", 32'(found), 32'd1);
    check("to_defer_cycles", 32'(n), 32'(TOUT));
    check("to_defer_no_set_en", 32'(stable), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
